// File: rtl/edge_arb_pkg.sv
// Shared types and constants for the edge-event arbiter.
package edge_arb_pkg;

  localparam int unsigned N_DEF      = 4;
  localparam int unsigned DROP_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Index width for n channels; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_tick.sv
// Per-channel rising-edge detector; history clears on reset so a level high at release yields one edge.
module edge_tick
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_edge_c
);

  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_edge_c = i_level & ~r_prev;

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects rising edges from N level inputs and offers them one at a time, round-robin,
// to a single consumer; edges hitting an already pending channel are counted as drops.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int unsigned N      = N_DEF,
  parameter  int unsigned DROP_W = DROP_W_DEF,
  localparam int unsigned ID_W   = id_width(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      level,
  input  logic              ev_ready,
  output logic              ev_valid,
  output logic [ID_W-1:0]   ev_id,
  input  logic              clear_drops,
  input  logic [ID_W-1:0]   drop_sel,
  output logic [DROP_W-1:0] drop_count,
  output logic [N-1:0]      overflow
);

  localparam int unsigned   SUM_W = ID_W + 1;
  localparam logic [SUM_W-1:0] N_SUM = SUM_W'(N);

  logic [N-1:0]      w_edge;
  logic [N-1:0]      w_hs_sel;
  logic [N-1:0]      w_drop;
  logic [N-1:0]      w_rot;
  logic [N-1:0]      r_pending;
  logic [N-1:0]      r_overflow;
  logic [DROP_W-1:0] r_drop_cnt [N];
  logic [ID_W-1:0]   w_first;
  logic [ID_W-1:0]   w_pick;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_inc;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_ev_id;
  logic [ID_W-1:0]   w_ev_id_nxt;
  logic              r_ev_valid;
  logic              w_hs;
  state_t            r_state;
  state_t            w_state_nxt;

  for (genvar g = 0; g < N; g++) begin : g_tick
    edge_tick u_tick (
      .clk      (clk),
      .reset    (reset),
      .i_level  (level[g]),
      .o_edge_c (w_edge[g])
    );
  end

  assign w_hs = r_ev_valid & ev_ready;

  // A handshaken channel is not a drop target, and its same-cycle edge re-arms it.
  always_comb begin
    w_hs_sel = '0;
    w_drop   = '0;
    for (int i = 0; i < N; i++) begin
      w_hs_sel[i] = w_hs & (r_ev_id == ID_W'(i));
      w_drop[i]   = w_edge[i] & r_pending[i] & ~w_hs_sel[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_edge[i])        r_pending[i] <= 1'b1;
        else if (w_hs_sel[i]) r_pending[i] <= 1'b0;
      end
    end
  end

  // Round-robin pick: rotate so rr_ptr sits at bit 0, find first set, rotate back.
  always_comb begin
    w_rot   = (r_pending >> r_rr_ptr) | (r_pending << (N - r_rr_ptr));
    w_first = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (w_rot[k]) w_first = ID_W'(k);
    end
    w_sum  = {1'b0, w_first} + {1'b0, r_rr_ptr};
    w_pick = (w_sum >= N_SUM) ? ID_W'(w_sum - N_SUM) : w_sum[ID_W-1:0];
    w_inc     = {1'b0, r_ev_id} + SUM_W'(1);
    w_ptr_nxt = (w_inc == N_SUM) ? '0 : w_inc[ID_W-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ev_id_nxt = r_ev_id;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_ev_id_nxt = w_pick;
          w_state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ev_valid <= 1'b0;
      r_ev_id    <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ev_valid <= (w_state_nxt == OFFER);
      r_ev_id    <= w_ev_id_nxt;
      if (w_hs) r_rr_ptr <= w_ptr_nxt;
    end
  end

  // Saturating drop counters; a clear wins over a same-cycle drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= '0;
      for (int i = 0; i < N; i++) r_drop_cnt[i] <= '0;
    end else if (clear_drops) begin
      r_overflow <= '0;
      for (int i = 0; i < N; i++) r_drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_drop[i]) begin
          r_overflow[i] <= 1'b1;
          if (r_drop_cnt[i] != '1) r_drop_cnt[i] <= r_drop_cnt[i] + DROP_W'(1);
        end
      end
    end
  end

  assign ev_valid   = r_ev_valid;
  assign ev_id      = r_ev_id;
  assign overflow   = r_overflow;
  assign drop_count = ({1'b0, drop_sel} < N_SUM) ? r_drop_cnt[drop_sel] : '0;

endmodule
